jsoc_sysid_checker: RTL and testbench
=====================================

// Module: jsoc_sysid_checker
// PURPOSE
//  Sequencer for the system-ID slave: on start (or automatically after reset) it issues two Avalon-MM reads.
//  - address 0 returns the system ID; address 1 returns the build timestamp.
//  - Captures both words and compares them with expected values.
//  - Reports pass/fail, the captured words and a saturating failure count to the CPU-side status logic.
// PARAMETERS
//  EXPECTED_ID   32'd0           expected word at sysid address 0
//  EXPECTED_TS   32'd1643105791  expected word at sysid address 1
//  READ_LATENCY  0               slave read latency in cycles, legal range 0..3
//  AUTO_START    1               1 = run one check automatically after reset release
// PORTS
//  clock          in   1   system clock, rising edge
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   1-cycle request to run a check; honoured only in IDLE
//  avm_address    out  1   sysid slave address (0 = ID, 1 = timestamp)
//  avm_read       out  1   read strobe to the sysid slave
//  avm_readdata   in   32  sysid slave read data
//  busy           out  1   high from the first read cycle until done
//  done           out  1   1-cycle pulse when a check completes
//  pass           out  1   id_match & ts_match of the last completed check
//  id_match       out  1   captured ID == EXPECTED_ID
//  ts_match       out  1   captured timestamp == EXPECTED_TS
//  id_value       out  32  captured ID word
//  ts_value       out  32  captured timestamp word
//  fail_count     out  8   number of failed checks, saturates at 255
// BEHAVIOUR
//  Reset: all outputs are 0, the FSM is in IDLE and fail_count = 0.
//   - Reset mid-check aborts the check with no partial update.
//  FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
//  IDLE
//   - Goes to RD_ID if start = 1.
//   - Also goes to RD_ID on the first clock edge after reset release when AUTO_START = 1 (internal 1-shot flag).
//  RD_ID
//   - Drives avm_read = 1 and avm_address = 0 for exactly 1 cycle; busy = 1.
//   - READ_LATENCY = 0: avm_readdata is captured into id_value at the end of this cycle; next state is RD_TS.
//   - READ_LATENCY > 0: next state is WAIT_ID.
//  WAIT_ID
//   - avm_read = 0; a down-counter runs READ_LATENCY cycles.
//   - Data is captured at the end of the last wait cycle; next state is RD_TS.
//  RD_TS / WAIT_TS
//   - Identical to RD_ID / WAIT_ID with avm_address = 1; data is captured into ts_value.
//   - On capture the next state is DONE.
//  DONE (1 cycle)
//   - done = 1; busy = 0 from this cycle onward.
//   - id_match, ts_match and pass are all updated at this cycle.
//   - fail_count increments if pass = 0, and holds at 255.
//   - Next state is IDLE.
//  Latency: done is high 3 + 2*READ_LATENCY cycles after the cycle in which start is sampled.
//  start is ignored in any state other than IDLE (no queueing), including the DONE cycle.
//  Result outputs hold their values until the next DONE; they are not cleared when a new check starts.
//  avm_address holds its last value while avm_read = 0.
//  Comparisons are full 32-bit equality; there is no masking.
// TESTING
//  1. AUTO_START=1, model returns 0 / 1643105791 -> done at cycle 3 after reset release, pass=1, fail_count=0.
//  2. Model returns timestamp 32'h12345678 on start -> ts_match=0, id_match=1, pass=0, fail_count=1.
//  3. READ_LATENCY=2, start pulse -> avm_read high in cycles 1 and 4, done in cycle 7, values correct.
//  4. Second start pulse while busy (and in the DONE cycle) -> ignored; exactly one done pulse seen.
//  5. reset_n low during WAIT_TS -> all outputs 0 immediately; after release an auto check runs and passes.
//  6. 260 failing checks -> fail_count stops at 255; one passing check leaves it at 255 with pass=1.

Source files
------------

// File: rtl/jsoc_sysid_checker.sv
// Sequencer that reads the system-ID slave (ID at address 0, build timestamp at address 1),
// compares both words against expected values and reports the result with a failure count.
module jsoc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1643105791,
  parameter int unsigned READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StWaitId,
    StRdTs,
    StWaitTs,
    StDone
  } state_e;

  localparam bit         NoWait   = (READ_LATENCY == 0);
  localparam logic [1:0] WaitInit = NoWait ? 2'd0 : 2'(READ_LATENCY - 1);

  state_e     state;
  logic [1:0] wait_cnt;
  logic       auto_pending;
  logic       id_capture;
  logic       ts_capture;
  logic       id_ok;
  logic       ts_ok;

  // Data is taken in the strobe cycle for a zero-latency slave, else in the last wait cycle.
  assign id_capture = ((state == StRdId) && NoWait) || ((state == StWaitId) && (wait_cnt == 2'd0));
  assign ts_capture = ((state == StRdTs) && NoWait) || ((state == StWaitTs) && (wait_cnt == 2'd0));
  assign id_ok      = (id_value == EXPECTED_ID);
  assign ts_ok      = (avm_readdata == EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      wait_cnt     <= 2'd0;
      auto_pending <= AUTO_START;
      avm_address  <= 1'b0;
      avm_read     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      id_match     <= 1'b0;
      ts_match     <= 1'b0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
      fail_count   <= 8'd0;
    end else begin
      avm_read <= 1'b0;
      done     <= 1'b0;
      case (state)
        StIdle: begin
          if (start || auto_pending) begin
            auto_pending <= 1'b0;
            state        <= StRdId;
            avm_read     <= 1'b1;
            avm_address  <= 1'b0;
            busy         <= 1'b1;
          end
        end
        StRdId, StWaitId: begin
          if (id_capture) begin
            id_value    <= avm_readdata;
            state       <= StRdTs;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
          end else if (state == StRdId) begin
            wait_cnt <= WaitInit;
            state    <= StWaitId;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        StRdTs, StWaitTs: begin
          if (ts_capture) begin
            // Results are published together with the done pulse.
            ts_value <= avm_readdata;
            id_match <= id_ok;
            ts_match <= ts_ok;
            pass     <= id_ok && ts_ok;
            if (!(id_ok && ts_ok) && (fail_count != 8'hFF)) begin
              fail_count <= fail_count + 8'd1;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end else if (state == StRdTs) begin
            wait_cnt <= WaitInit;
            state    <= StWaitTs;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jsoc_sysid_checker.sv
// Directed bench: one zero-latency instance (a) and one READ_LATENCY=2 instance (b),
// each served by a small sysid slave model.
module tb_jsoc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1643105791;

  logic        clock = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        addr_a, read_a, busy_a, done_a, pass_a, idm_a, tsm_a;
  logic        addr_b, read_b, busy_b, done_b, pass_b, idm_b, tsm_b;
  logic [31:0] rdata_a, idv_a, tsv_a, rdata_b, idv_b, tsv_b;
  logic [7:0]  fc_a, fc_b;
  logic [31:0] sl_id_a = EXP_ID, sl_ts_a = EXP_TS, sl_id_b = EXP_ID, sl_ts_b = EXP_TS;
  logic        v1 = 1'b0, v2 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clock = ~clock;

  // Zero-latency slave: data only valid while the strobe is up.
  assign rdata_a = read_a ? (addr_a ? sl_ts_a : sl_id_a) : 32'hDEADBEEF;

  // Two-cycle slave: data valid only in the second cycle after the strobe.
  always @(posedge clock) begin
    v1 <= read_b;
    a1 <= addr_b;
    v2 <= v1;
    a2 <= a1;
  end
  assign rdata_b = v2 ? (a2 ? sl_ts_b : sl_id_b) : 32'hDEADBEEF;

  jsoc_sysid_checker #(.READ_LATENCY(0)) dut_a (
    .clock(clock), .reset_n(rst_a), .start(start_a), .avm_address(addr_a), .avm_read(read_a),
    .avm_readdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a), .id_match(idm_a),
    .ts_match(tsm_a), .id_value(idv_a), .ts_value(tsv_a), .fail_count(fc_a)
  );

  jsoc_sysid_checker #(.READ_LATENCY(2)) dut_b (
    .clock(clock), .reset_n(rst_b), .start(start_b), .avm_address(addr_b), .avm_read(read_b),
    .avm_readdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b), .id_match(idm_b),
    .ts_match(tsm_b), .id_value(idv_b), .ts_value(tsv_b), .fail_count(fc_b)
  );

  // Launches a check (start pulse or reset release) in cycle 0 and records cycles 1..budget.
  // start stays high until the negedge of cycle 'hold'.
  task automatic run(input bit sel, input bit from_reset, input int hold, input int budget,
                     output int done_cyc, output int n_done,
                     output logic [15:0] rd_mask, output logic [15:0] addr_mask);
    done_cyc  = -1;
    n_done    = 0;
    rd_mask   = '0;
    addr_mask = '0;
    @(negedge clock);
    if (from_reset) begin
      if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    end else begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (c == hold) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if ((sel ? read_b : read_a) === 1'b1) begin
        rd_mask[c]   = 1'b1;
        addr_mask[c] = sel ? addr_b : addr_a;
      end
      if ((sel ? done_b : done_a) === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    nchk++; if ({busy_a, done_a, pass_a, idm_a, tsm_a, read_a, addr_a} !== 7'b0) begin
      nerr++; $display("FAIL reset_flags_a: got %b want 0", {busy_a, done_a, pass_a, idm_a, tsm_a, read_a, addr_a});
    end
    nchk++; if ({idv_a, tsv_a, fc_a} !== 72'd0) begin
      nerr++; $display("FAIL reset_values_a: got %h want 0", {idv_a, tsv_a, fc_a});
    end
    nchk++; if ({busy_b, done_b, pass_b, read_b, fc_b, tsv_b} !== 44'd0) begin
      nerr++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, pass_b, read_b, fc_b, tsv_b});
    end
  endtask

  task automatic test_auto_start;
    int dc, nd;
    logic [15:0] rm, am;
    run(1'b0, 1'b1, 0, 6, dc, nd, rm, am);
    nchk++; if (dc !== 3 || nd !== 1) begin
      nerr++; $display("FAIL auto_done_a: got cycle %0d count %0d want cycle 3 count 1", dc, nd);
    end
    nchk++; if (rm !== 16'h0006 || am !== 16'h0004) begin
      nerr++; $display("FAIL auto_reads_a: got rd %h addr %h want rd 0006 addr 0004", rm, am);
    end
    nchk++; if ({pass_a, idm_a, tsm_a, fc_a} !== {3'b111, 8'd0} || tsv_a !== EXP_TS || idv_a !== EXP_ID) begin
      nerr++; $display("FAIL auto_result_a: got pass %b fc %0d ts %0d id %0d want pass 1 fc 0 ts %0d id 0",
                       pass_a, fc_a, tsv_a, idv_a, EXP_TS);
    end
    run(1'b1, 1'b1, 0, 10, dc, nd, rm, am);
    nchk++; if (dc !== 7 || nd !== 1 || rm !== 16'h0012 || am !== 16'h0010) begin
      nerr++; $display("FAIL auto_b: got done %0d cnt %0d rd %h addr %h want 7 1 0012 0010", dc, nd, rm, am);
    end
  endtask

  task automatic test_ts_mismatch;
    int dc, nd;
    logic [15:0] rm, am;
    sl_ts_a = 32'h12345678;
    run(1'b0, 1'b0, 1, 5, dc, nd, rm, am);
    nchk++; if (dc !== 3) begin
      nerr++; $display("FAIL start_latency_a: got %0d want 3", dc);
    end
    nchk++; if ({idm_a, tsm_a, pass_a} !== 3'b100 || fc_a !== 8'd1 || tsv_a !== 32'h12345678) begin
      nerr++; $display("FAIL ts_mismatch: got idm/tsm/pass %b fc %0d ts %h want 100 1 12345678",
                       {idm_a, tsm_a, pass_a}, fc_a, tsv_a);
    end
    sl_ts_a = EXP_TS;
  endtask

  task automatic test_id_mismatch;
    int dc, nd;
    logic [15:0] rm, am;
    sl_id_a = 32'h8000_0000;
    run(1'b0, 1'b0, 1, 5, dc, nd, rm, am);
    nchk++; if ({idm_a, tsm_a, pass_a} !== 3'b010 || fc_a !== 8'd2 || idv_a !== 32'h8000_0000) begin
      nerr++; $display("FAIL id_mismatch: got idm/tsm/pass %b fc %0d id %h want 010 2 80000000",
                       {idm_a, tsm_a, pass_a}, fc_a, idv_a);
    end
    sl_id_a = EXP_ID;
  endtask

  task automatic test_latency;
    int dc, nd;
    logic [15:0] rm, am;
    sl_ts_b = 32'hCAFE_0001;
    run(1'b1, 1'b0, 1, 10, dc, nd, rm, am);
    nchk++; if (dc !== 7 || rm !== 16'h0012 || am !== 16'h0010) begin
      nerr++; $display("FAIL lat2_timing: got done %0d rd %h addr %h want 7 0012 0010", dc, rm, am);
    end
    nchk++; if (tsv_b !== 32'hCAFE_0001 || pass_b !== 1'b0 || fc_b !== 8'd1) begin
      nerr++; $display("FAIL lat2_fail: got ts %h pass %b fc %0d want cafe0001 0 1", tsv_b, pass_b, fc_b);
    end
    sl_ts_b = EXP_TS;
    run(1'b1, 1'b0, 1, 10, dc, nd, rm, am);
    nchk++; if (tsv_b !== EXP_TS || idv_b !== EXP_ID || pass_b !== 1'b1 || fc_b !== 8'd1) begin
      nerr++; $display("FAIL lat2_pass: got ts %0d id %0d pass %b fc %0d want %0d 0 1 1",
                       tsv_b, idv_b, pass_b, fc_b, EXP_TS);
    end
  endtask

  task automatic test_back_to_back;
    int dc, nd;
    logic [15:0] rm, am;
    run(1'b0, 1'b0, 4, 12, dc, nd, rm, am);
    nchk++; if (dc !== 3 || nd !== 1 || rm !== 16'h0006) begin
      nerr++; $display("FAIL busy_start_a: got done %0d cnt %0d rd %h want 3 1 0006", dc, nd, rm);
    end
    run(1'b1, 1'b0, 8, 15, dc, nd, rm, am);
    nchk++; if (dc !== 7 || nd !== 1 || rm !== 16'h0012) begin
      nerr++; $display("FAIL busy_start_b: got done %0d cnt %0d rd %h want 7 1 0012", dc, nd, rm);
    end
  endtask

  task automatic test_reset_mid_check;
    int dc, nd;
    logic [15:0] rm, am;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    repeat (4) @(negedge clock);  // now in cycle 5 (WAIT_TS)
    nchk++; if (busy_b !== 1'b1 || fc_b !== 8'd1) begin
      nerr++; $display("FAIL pre_abort_b: got busy %b fc %0d want 1 1", busy_b, fc_b);
    end
    rst_b = 1'b0;
    #1;
    nchk++; if ({busy_b, done_b, pass_b, idm_b, tsm_b, read_b, addr_b, fc_b, idv_b, tsv_b} !== 79'd0) begin
      nerr++; $display("FAIL abort_b: got %h want 0",
                       {busy_b, done_b, pass_b, idm_b, tsm_b, read_b, addr_b, fc_b, idv_b, tsv_b});
    end
    repeat (2) @(negedge clock);
    run(1'b1, 1'b1, 0, 10, dc, nd, rm, am);
    nchk++; if (dc !== 7 || nd !== 1 || pass_b !== 1'b1 || tsv_b !== EXP_TS || fc_b !== 8'd0) begin
      nerr++; $display("FAIL reauto_b: got done %0d cnt %0d pass %b ts %0d fc %0d want 7 1 1 %0d 0",
                       dc, nd, pass_b, tsv_b, fc_b, EXP_TS);
    end
  endtask

  task automatic test_saturation;
    int dc, nd;
    logic [15:0] rm, am;
    sl_ts_a = 32'h0000_0BAD;
    for (int i = 1; i <= 260; i++) begin
      run(1'b0, 1'b0, 1, 4, dc, nd, rm, am);
      if (i == 252) begin
        nchk++; if (fc_a !== 8'd254) begin
          nerr++; $display("FAIL count_254: got %0d want 254", fc_a);
        end
      end
    end
    nchk++; if (fc_a !== 8'd255 || pass_a !== 1'b0) begin
      nerr++; $display("FAIL count_sat: got fc %0d pass %b want 255 0", fc_a, pass_a);
    end
    sl_ts_a = EXP_TS;
    run(1'b0, 1'b0, 1, 5, dc, nd, rm, am);
    nchk++; if (fc_a !== 8'd255 || pass_a !== 1'b1 || dc !== 3) begin
      nerr++; $display("FAIL count_hold: got fc %0d pass %b done %0d want 255 1 3", fc_a, pass_a, dc);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_id_mismatch();
    test_latency();
    test_back_to_back();
    test_reset_mid_check();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
